// File: rtl/vec_load_unit.sv
// ============================================================================
// vec_load_unit : gathers LANES bytes into one vector and writes it to the VRF.
// Optional macro VLOAD_TIMEOUT_EN adds a per-element WAIT timeout. Rev 1.0
// ============================================================================
`default_nettype none

module vec_load_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int LANES          = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int TIMEOUT        = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [MEM_ADDR_WIDTH-1:0]        baseAddr,
  input  logic [REG_ADDR_WIDTH-1:0]        destReg,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             memRdEn,
  output logic [MEM_ADDR_WIDTH-1:0]        memAddr,
  input  logic [DATA_WIDTH-1:0]            memRdData,
  input  logic                             memRdValid,
  output logic                             regWrEn,
  output logic [REG_ADDR_WIDTH-1:0]        regToWrite,
  output logic [LANES*DATA_WIDTH-1:0]      regWriteData
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

  state_t                          state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]       base_q, base_d;
  logic [REG_ADDR_WIDTH-1:0]       dest_q, dest_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [LANES*DATA_WIDTH-1:0]     vbuf_q, vbuf_d;

`ifdef VLOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]                tmo_q, tmo_d;
  logic                            timeout_w;

  assign timeout_w = (state_q == S_WAIT) && !memRdValid &&
                     (tmo_q == TMO_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    vbuf_d  = vbuf_q;
`ifdef VLOAD_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = baseAddr;
          dest_d  = destReg;
          idx_d   = '0;
          vbuf_d  = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
`ifdef VLOAD_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (memRdValid) begin
          // first fetched byte lands in the most significant element
          vbuf_d[(LANES - 1 - int'(idx_q)) * DATA_WIDTH +: DATA_WIDTH] = memRdData;
          if (idx_q == IDX_W'(LANES - 1)) begin
            state_d = S_WRITE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_REQ;
          end
        end
`ifdef VLOAD_TIMEOUT_EN
        else if (timeout_w) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      dest_q  <= '0;
      idx_q   <= '0;
      vbuf_q  <= '0;
`ifdef VLOAD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      vbuf_q  <= vbuf_d;
`ifdef VLOAD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign memRdEn      = (state_q == S_REQ);
  assign memAddr      = (state_q == S_REQ) ? (base_q + MEM_ADDR_WIDTH'(idx_q)) : '0;
  assign regWrEn      = (state_q == S_WRITE);
  assign done         = (state_q == S_WRITE);
  assign regToWrite   = (state_q == S_WRITE) ? dest_q : '0;
  assign regWriteData = vbuf_q;

`ifdef VLOAD_TIMEOUT_EN
  assign err = timeout_w;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_load_unit.sv
// Scoreboard bench for vec_load_unit: a memory responder feeds the DUT, a monitor
// checks read addresses and register writes against queued expectations.
`default_nettype none

module tb_vec_load_unit;

  localparam int DW    = 8;
  localparam int LANES = 4;
  localparam int RAW   = 3;
  localparam int MAW   = 16;
  localparam int TMO   = 15;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [MAW-1:0]      baseAddr;
  logic [RAW-1:0]      destReg;
  logic                busy, done, err, memRdEn, memRdValid, regWrEn;
  logic [MAW-1:0]      memAddr;
  logic [DW-1:0]       memRdData;
  logic [RAW-1:0]      regToWrite;
  logic [LANES*DW-1:0] regWriteData;

  vec_load_unit #(
    .DATA_WIDTH(DW), .LANES(LANES), .REG_ADDR_WIDTH(RAW),
    .MEM_ADDR_WIDTH(MAW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
    .destReg(destReg), .busy(busy), .done(done), .err(err),
    .memRdEn(memRdEn), .memAddr(memAddr), .memRdData(memRdData),
    .memRdValid(memRdValid), .regWrEn(regWrEn), .regToWrite(regToWrite),
    .regWriteData(regWriteData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [RAW-1:0]      dest;
    logic [LANES*DW-1:0] data;
    int                  scyc;
    bit                  chk_lat;
  } wr_t;

  wr_t            exp_q[$];
  logic [MAW-1:0] addr_q[$];
  logic [DW-1:0]  mem [0:65535];
  int             dly [LANES];
  int             hold_el  = -1;
  int             spur_el  = -1;
  int             rsp_idx  = 0;
  int             hold_cyc = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Memory model: answers each read request after 1+dly[el] cycles
  initial begin
    int el;
    logic [MAW-1:0] a;
    memRdValid = 1'b0;
    memRdData  = '0;
    forever begin
      @(negedge clk);
      memRdValid = 1'b0;
      if (reset && memRdEn) begin
        el = rsp_idx;
        a  = memAddr;
        rsp_idx++;
        if (el == spur_el) begin
          memRdValid = 1'b1;
          memRdData  = 8'h5A;
        end
        if (el == hold_el) begin
          hold_cyc = cyc;
        end else begin
          repeat ((el < LANES) ? dly[el] : 0) begin
            @(negedge clk);
            memRdValid = 1'b0;
          end
          @(negedge clk);
          memRdValid = 1'b1;
          memRdData  = mem[a];
        end
      end
    end
  end

  // Monitor: every read address and every register write is checked against the queues
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (memRdEn) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=%0h required=none", memAddr);
        end else begin
          chk("mem_addr", 64'(memAddr), 64'(addr_q.pop_front()));
        end
      end
      if (regWrEn) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write actual=reg%0d data=%0h required=none",
                   regToWrite, regWriteData);
        end else begin
          e = exp_q.pop_front();
          chk("reg_to_write", 64'(regToWrite), 64'(e.dest));
          chk("reg_write_data", 64'(regWriteData), 64'(e.data));
          chk("done_with_write", 64'(done), 64'd1);
          if (e.chk_lat) chk("write_latency", 64'(cyc - e.scyc + 1), 64'(2 * LANES + 1));
        end
      end
      if (done && !regWrEn) begin
        checks++; failures++;
        $display("FAIL done_without_write actual=1 required=0");
      end
`ifndef VLOAD_TIMEOUT_EN
      if (err) begin
        checks++; failures++;
        $display("FAIL err_tied_low actual=1 required=0");
      end
`endif
    end
  end

  // Called mid-cycle with the DUT idle; returns 1ns after the sampling edge
  task automatic issue(input logic [MAW-1:0] base, input logic [RAW-1:0] dest,
                       input logic [LANES*DW-1:0] data, input bit expect_wr,
                       input bit chk_lat);
    wr_t e;
    baseAddr = base;
    destReg  = dest;
    start    = 1'b1;
    rsp_idx  = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_wr) begin
      e.dest = dest; e.data = data; e.scyc = cyc; e.chk_lat = chk_lat;
      exp_q.push_back(e);
    end
    for (int k = 0; k < LANES; k++) addr_q.push_back(base + MAW'(k));
  endtask

  task automatic wait_write(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!regWrEn && n < bound);
    if (!regWrEn) begin
      checks++; failures++;
      $display("FAIL write_timeout actual=none required=regWrEn");
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_memrden", 64'(memRdEn), 64'd0);
    chk("reset_data", 64'(regWriteData), 64'd0);
    addr_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int  n;
    bit  got;
    for (int k = 0; k < 65536; k++) mem[k] = 8'h00;
    for (int k = 0; k < LANES; k++) dly[k] = 0;
    reset = 1'b0; start = 1'b0; baseAddr = '0; destReg = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_memrden", 64'(memRdEn), 64'd0);
    chk("rst_memaddr", 64'(memAddr), 64'd0);
    chk("rst_regwren", 64'(regWrEn), 64'd0);
    chk("rst_regtowrite", 64'(regToWrite), 64'd0);
    chk("rst_regwritedata", 64'(regWriteData), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic load
    mem[16'h0010] = 8'hDE; mem[16'h0011] = 8'hAD; mem[16'h0012] = 8'hBE; mem[16'h0013] = 8'hEF;
    issue(16'h0010, 3'd1, 32'hDEADBEEF, 1'b1, 1'b1);
    drain(40);

    // Address wrap with a slow element 1
    mem[16'hFFFE] = 8'h1A; mem[16'hFFFF] = 8'h2B; mem[16'h0000] = 8'h3C; mem[16'h0001] = 8'h4D;
    dly[1] = 3;
    issue(16'hFFFE, 3'd7, 32'h1A2B3C4D, 1'b1, 1'b0);
    drain(60);
    dly[1] = 0;

    // Stray start while busy and stray valid during REQ, then back-to-back loads
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33; mem[16'h0023] = 8'h44;
    mem[16'h0100] = 8'hAA; mem[16'h0101] = 8'hBB; mem[16'h0102] = 8'hCC; mem[16'h0103] = 8'hDD;
    mem[16'h0030] = 8'h55; mem[16'h0031] = 8'h66; mem[16'h0032] = 8'h77; mem[16'h0033] = 8'h88;
    mem[16'h0040] = 8'h9A; mem[16'h0041] = 8'hBC; mem[16'h0042] = 8'hDE; mem[16'h0043] = 8'hF0;
    spur_el = 1;
    issue(16'h0020, 3'd3, 32'h11223344, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    baseAddr = 16'h0100; destReg = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spur_el = -1;
    wait_write(30);
    @(negedge clk);
    issue(16'h0030, 3'd2, 32'h55667788, 1'b1, 1'b1);
    wait_write(30);
    @(negedge clk);
    issue(16'h0040, 3'd4, 32'h9ABCDEF0, 1'b1, 1'b1);
    drain(40);

    // Result persists while idle
    repeat (3) @(negedge clk);
    chk("hold_data", 64'(regWriteData), 64'h9ABCDEF0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Reset in the middle of a load: no write, buffer cleared
    mem[16'h0050] = 8'h01; mem[16'h0051] = 8'h02; mem[16'h0052] = 8'h03; mem[16'h0053] = 8'h04;
    issue(16'h0050, 3'd6, '0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    pulse_reset();
    repeat (10) @(negedge clk);
    chk("post_abort_data", 64'(regWriteData), 64'd0);
    chk("post_abort_busy", 64'(busy), 64'd0);

    // Element 2 never answered
    hold_el = 2;
    issue(16'h0060, 3'd5, '0, 1'b0, 1'b0);
`ifdef VLOAD_TIMEOUT_EN
    got = 1'b0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if (err) got = 1'b1;
    end
    chk("err_seen", 64'(got), 64'd1);
    chk("err_wait_cycles", 64'(cyc - hold_cyc), 64'(TMO));
    chk("err_no_write", 64'(regWrEn), 64'd0);
    @(negedge clk);
    chk("err_busy_after", 64'(busy), 64'd0);
    chk("err_single_pulse", 64'(err), 64'd0);
    addr_q.delete();
`else
    got = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_forever_busy", 64'(busy), 64'd1);
    chk("wait_forever_err", 64'(err), 64'(got));
    pulse_reset();
`endif
    hold_el = -1;
    repeat (3) @(negedge clk);
    chk("addr_queue_empty", 64'(addr_q.size()), 64'd0);
    chk("write_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire

// File: doc/vec_load_unit.md
Name: vec_load_unit

Overview:
- Vector load stage that sits directly upstream of the vector register file's write port.
- On a start command it fetches LANES consecutive elements from a byte-wide data memory and packs them into one vector.
- It then issues a single-cycle write of that vector to the destination vector register.
- Its outputs regWrEn, regToWrite and regWriteData connect straight to the register file ports of the same names.

Parameters:
DATA_WIDTH, 8, element width in bits; also the memory data width
LANES, 4, elements per vector
REG_ADDR_WIDTH, 3, vector register index width
MEM_ADDR_WIDTH, 16, memory address width
TIMEOUT, 15, max WAIT cycles per element (used only with VLOAD_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset
start  in  1  load request, sampled only in IDLE
baseAddr  in  MEM_ADDR_WIDTH  address of first element, sampled with start
destReg  in  REG_ADDR_WIDTH  destination vector register, sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, coincident with regWrEn
err  out  1  one-cycle pulse on timeout abort (tied 0 without VLOAD_TIMEOUT_EN)
memRdEn  out  1  one-cycle read request
memAddr  out  MEM_ADDR_WIDTH  read address, valid while memRdEn=1
memRdData  in  DATA_WIDTH  read data, valid while memRdValid=1
memRdValid  in  1  read data valid
regWrEn  out  1  register file write enable
regToWrite  out  REG_ADDR_WIDTH  destination register
regWriteData  out  LANES*DATA_WIDTH  packed vector, element [LANES-1] in the MSBs

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; lane counter=0; vector buffer=0. All outputs (busy, done, err, memRdEn, memAddr, regWrEn, regToWrite, regWriteData) are 0.
- Reset asserted mid-operation aborts the load. No register write occurs, and any later memRdValid is ignored.
- States:
  - IDLE: start=1 latches baseAddr/destReg, clears lane counter i and buffer, goes to REQ.
  - REQ: memRdEn=1 and memAddr=baseAddr+i for exactly one cycle, then WAIT.
  - WAIT: on memRdValid=1 store memRdData. If i<LANES-1, increment i and go to REQ; otherwise go to WRITE.
  - WRITE: regWrEn=1, done=1, regToWrite=latched destReg, regWriteData=buffer for one cycle, then IDLE.
- Element ordering: the byte at baseAddr+k goes to element [LANES-1-k]. Example: bytes DE,AD,BE,EF at ascending addresses give regWriteData=32'hDEADBEEF.
- Address arithmetic is modulo 2^MEM_ADDR_WIDTH, so baseAddr=16'hFFFE reads FFFE, FFFF, 0000, 0001.
- memRdValid is accepted only in WAIT. In IDLE, REQ and WRITE it is ignored.
- start is ignored while busy=1, and also during the WRITE cycle.
- start in the cycle after WRITE (back in IDLE) is accepted normally.
- Latency with memRdValid arriving the cycle after memRdEn: regWrEn is asserted 2*LANES+1 cycles after the edge that samples start, i.e. 9 cycles for LANES=4.
- regWriteData holds the last written vector between loads. It returns to 0 only on reset or on a new start.

Optional Feature:
- Macro VLOAD_TIMEOUT_EN.
- Defined:
  - A per-element counter runs in WAIT. It is cleared on each entry to WAIT.
  - If memRdValid is not seen within TIMEOUT cycles, the unit pulses err for one cycle and returns to IDLE.
  - In that case regWrEn and done are not asserted.
- Not defined:
  - WAIT waits indefinitely.
  - err is constant 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> busy, done, err, memRdEn, regWrEn all 0 and regWriteData=0. Assert reset=0 mid-load -> state IDLE immediately, no regWrEn.
- Basic load: baseAddr=16'h0010, destReg=1, memory returns DE,AD,BE,EF with 1-cycle latency -> memAddr sequence 0010..0013, regWrEn=1 with regToWrite=1 and regWriteData=32'hDEADBEEF exactly 9 cycles after start, done coincident.
- Variable latency and wrap: baseAddr=16'hFFFE, destReg=7, memRdValid delayed 3 cycles on element 1 -> addresses FFFE, FFFF, 0000, 0001; data 1A,2B,3C,4D gives regWriteData=32'h1A2B3C4D, written to register 7.
- Ignored inputs: pulse start with baseAddr=16'h0100 while busy, and pulse a spurious memRdValid in REQ -> the original load completes unchanged and exactly one regWrEn occurs.
- Back-to-back: start again the cycle after done with destReg=2 -> second load begins, and each load produces one write with correct data.
- With VLOAD_TIMEOUT_EN and TIMEOUT=15: withhold memRdValid on element 2 -> err pulses once after 15 WAIT cycles, no regWrEn, busy=0 next cycle. Without the macro, the same stimulus keeps busy=1 indefinitely with err=0.
